// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the multi-cycle shifter: op codes, FSM states and op decoding.
// Imported by the shifter top and its combinational step slice.
package seq_shift_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Codes 101..111 have no meaning and are reported through out_err.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational slice shifting/rotating WIDTH-bit data by k (0..STEP_MAX) for one op,
// returning the shifted word and the last bit that left the word.
module shift_step
    import seq_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned STEP_MAX = 4,
    parameter int unsigned K_W      = $clog2(STEP_MAX + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [K_W-1:0]   k,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH-1:0] pre_l;
    logic [WIDTH-1:0] pre_r;

    // Shifting by k-1 parks the final outgoing bit at the word edge for carry extraction.
    assign pre_l = data << (k - K_W'(1));
    assign pre_r = data >> (k - K_W'(1));

    always_comb begin
        res   = data;
        carry = 1'b0;
        case (op)
            OP_SLL: begin
                res   = data << k;
                carry = pre_l[WIDTH-1];
            end
            OP_SRL: begin
                res   = data >> k;
                carry = pre_r[0];
            end
            OP_SRA: begin
                res   = $signed(data) >>> k;
                carry = pre_r[0];
            end
            OP_ROL: begin
                res   = (data << k) | (data >> (WIDTH - k));
                carry = pre_l[WIDTH-1];
            end
            OP_ROR: begin
                res   = (data >> k) | (data << (WIDTH - k));
                carry = pre_r[0];
            end
            default: begin
                res   = data;
                carry = 1'b0;
            end
        endcase
        if (k == '0) begin
            res   = data;
            carry = 1'b0;
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROL/ROR) advancing SHIFT_PER_CYC bits per clock,
// with valid/ready handshakes and carry/zero/error flags for the ALU flag logic.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SHAMT_W       = $clog2(WIDTH),
    parameter int unsigned SHIFT_PER_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [OP_W-1:0]    in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_zero,
    output logic               out_err
);

    localparam int unsigned K_W = $clog2(SHIFT_PER_CYC + 1);

    state_e             state_q, state_n;
    logic [WIDTH-1:0]   data_q, data_n;
    logic [OP_W-1:0]    op_q, op_n;
    logic [SHAMT_W-1:0] cnt_q, cnt_n;
    logic               carry_q, carry_n;
    logic               err_q, err_n;

    logic [K_W-1:0]     step;
    logic               last_step;
    logic [WIDTH-1:0]   step_res;
    logic               step_carry;

    assign last_step = cnt_q <= SHAMT_W'(SHIFT_PER_CYC);
    assign step      = last_step ? K_W'(cnt_q) : K_W'(SHIFT_PER_CYC);

    shift_step #(
        .WIDTH    (WIDTH),
        .STEP_MAX (SHIFT_PER_CYC),
        .K_W      (K_W)
    ) u_step (
        .data  (data_q),
        .k     (step),
        .op    (shift_op_e'(op_q)),
        .res   (step_res),
        .carry (step_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            op_q    <= op_n;
            cnt_q   <= cnt_n;
            carry_q <= carry_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        op_n    = op_q;
        cnt_n   = cnt_q;
        carry_n = carry_q;
        err_n   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_n  = in_a;
                    op_n    = in_op;
                    cnt_n   = in_shamt;
                    carry_n = 1'b0;
                    err_n   = !op_legal(in_op);
                    // Zero amounts and illegal ops bypass RUN and return the operand unchanged.
                    if (in_shamt == '0 || !op_legal(in_op)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                data_n  = step_res;
                carry_n = step_carry;
                cnt_n   = cnt_q - SHAMT_W'(step);
                if (last_step) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_err   = err_q;
    assign out_zero  = data_q == '0;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomised and directed checks of seq_shift_unit against a whole-amount arithmetic model.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;

    seq_shift_unit #(
        .WIDTH         (32),
        .SHAMT_W       (5),
        .SHIFT_PER_CYC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Returns {err, carry, data} for shifting a by the full amount s in one go.
    function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a, input int unsigned s);
        logic [63:0]        t;
        logic signed [63:0] ts;
        logic [31:0]        d;
        logic               c;
        if (op > 3'd4) return {1'b1, 1'b0, a};
        if (s == 0) return {2'b00, a};
        d = a;
        c = 1'b0;
        case (op)
            3'd0: begin t = {32'b0, a} << s; d = t[31:0]; c = t[32]; end
            3'd1: begin t = {a, 32'b0} >> s; d = t[63:32]; c = t[31]; end
            3'd2: begin ts = {a, 32'b0}; ts = ts >>> s; d = ts[63:32]; c = ts[31]; end
            3'd3: begin d = (a << s) | (a >> (32 - s)); c = d[0]; end
            default: begin d = (a >> s) | (a << (32 - s)); c = d[31]; end
        endcase
        return {1'b0, c, d};
    endfunction

    function automatic int model_lat(input logic [2:0] op, input int unsigned s);
        if (s == 0 || op > 3'd4) return 1;
        return 1 + int'((s + 3) / 4);
    endfunction

    // Presents one request right after a clock edge and waits for the result in DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [4:0] s);
        int          lat;
        logic [33:0] exp;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_shamt = s;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_a     = $urandom;
            lat++;
        end while (!out_valid && lat < 40);
        exp = model(op, a, int'(s));
        chk("latency", 32'(lat), 32'(model_lat(op, int'(s))));
        chk("data", out_data, exp[31:0]);
        chk("carry", {31'b0, out_carry}, {31'b0, exp[32]});
        chk("zero", {31'b0, out_zero}, {31'b0, exp[31:0] == 32'd0});
        chk("err", {31'b0, out_err}, {31'b0, exp[33]});
        chk("busy_ready", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held_data;
        logic        held_carry;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_data", out_data, 32'd0);
        chk("rst_zero", {31'b0, out_zero}, 32'd1);
        chk("rst_carry", {31'b0, out_carry}, 32'd0);
        chk("rst_err", {31'b0, out_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'h0000_0001, 5'd31);
        chk("sll31", out_data, 32'h8000_0000);
        release_op();
        run_op(3'd2, 32'h8000_0000, 5'd4);
        chk("sra4", out_data, 32'hF800_0000);
        release_op();
        run_op(3'd1, 32'h8000_0000, 5'd4);
        chk("srl4", out_data, 32'h0800_0000);
        release_op();
        run_op(3'd4, 32'h0000_0001, 5'd1);
        chk("ror1", out_data, 32'h8000_0000);
        chk("ror1_c", {31'b0, out_carry}, 32'd1);
        release_op();
        run_op(3'd3, 32'h8000_00F0, 5'd4);
        chk("rol4", out_data, 32'h0000_0F08);
        release_op();
        run_op(3'd1, 32'h1234_5678, 5'd0);
        chk("srl0", out_data, 32'h1234_5678);
        release_op();
        run_op(3'd7, 32'hCAFE_0001, 5'd9);
        chk("illegal", {31'b0, out_err}, 32'd1);
        release_op();
        run_op(3'd0, 32'hFFFF_FFFF, 5'd31);
        held_data = out_data;
        release_op();
        run_op(3'd1, held_data, 5'd31);
        chk("chain", out_data, 32'h0000_0001);
        release_op();

        // Backpressure with a stray request while the result is held
        run_op(3'd2, 32'h9ABC_DEF0, 5'd13);
        held_data  = out_data;
        held_carry = out_carry;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_a     = 32'h1111_1111;
            in_op    = 3'd0;
            in_shamt = 5'd0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", out_data, held_data);
            chk("hold_carry", {31'b0, out_carry}, {31'b0, held_carry});
            chk("hold_ready", {31'b0, in_ready}, 32'd0);
        end
        release_op();
        run_op(3'd3, 32'h0F00_000F, 5'd8);
        release_op();

        // Reset during RUN
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'hDEAD_BEEF;
        in_shamt = 5'd31;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(3'd0, 32'h0000_0003, 5'd2);
        chk("post_rst", out_data, 32'h0000_000C);
        release_op();

        for (int n = 0; n < 60; n++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            release_op();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
